// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that merges NUM_PORTS request channels onto one memory port.
// It keeps an in-order tag FIFO and uses it to route memory responses back to the requesting port.
module mem_req_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    output logic [NUM_PORTS-1:0]                   req_ready,
    input  logic [NUM_PORTS-1:0][1:0]              req_op,
    input  logic [NUM_PORTS-1:0][1:0]              req_size,
    input  logic [NUM_PORTS-1:0]                   req_sign,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]                   resp_valid,
    output logic [DATA_WIDTH-1:0]                  resp_rdata,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [1:0]                             mem_req_op,
    output logic [1:0]                             mem_req_size,
    output logic                                   mem_req_sign,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    output logic [DATA_WIDTH-1:0]                  mem_req_wdata,
    input  logic                                   mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                  mem_resp_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]       outstanding,
    output logic                                   err_orphan
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(MAX_OUTSTANDING);

    typedef struct packed {
        logic [1:0]            op;
        logic [1:0]            size;
        logic                  sign;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    // Per-port request FIFOs
    req_t           r_fifo_mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW:0]    r_wr_ptr   [NUM_PORTS];
    logic [AW:0]    r_rd_ptr   [NUM_PORTS];
    req_t           w_req_in   [NUM_PORTS];
    req_t           w_head     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;

    // Arbitration and grant lock
    logic [PW-1:0]  r_rr_ptr;
    logic [PW-1:0]  r_grant;
    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_arb_valid;
    logic [PW-1:0]  w_arb_port;
    logic [PW-1:0]  w_grant;
    logic           w_issue;
    logic           w_accept;

    // Tag FIFO holding the port ID of every issued request, oldest first
    logic [PW-1:0]  r_tag_mem [MAX_OUTSTANDING];
    logic [TW-1:0]  r_tag_wr;
    logic [TW-1:0]  r_tag_rd;
    logic [TW:0]    r_tag_count;
    logic           w_tag_full;
    logic           w_resp_fire;
    logic           r_err;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_req_in[p] = '{op: req_op[p], size: req_size[p], sign: req_sign[p],
                            addr: req_addr[p], wdata: req_wdata[p]};
            w_full[p]   = (r_wr_ptr[p][AW] != r_rd_ptr[p][AW]) &&
                          (r_wr_ptr[p][AW-1:0] == r_rd_ptr[p][AW-1:0]);
            w_empty[p]  = (r_wr_ptr[p] == r_rd_ptr[p]);
            w_push[p]   = req_valid[p] && !w_full[p];
            w_head[p]   = r_fifo_mem[p][r_rd_ptr[p][AW-1:0]];
        end
    end

    assign req_ready = ~w_full;

    // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_push[p]) begin
                r_fifo_mem[p][r_wr_ptr[p][AW-1:0]] <= w_req_in[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_wr_ptr[p] <= '0;
                r_rd_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_push[p]) begin
                    r_wr_ptr[p] <= r_wr_ptr[p] + (AW+1)'(1);
                end
                if (w_accept && (int'(w_grant) == p)) begin
                    r_rd_ptr[p] <= r_rd_ptr[p] + (AW+1)'(1);
                end
            end
        end
    end

    // The search runs from farthest to nearest, so the nearest non-empty port after r_rr_ptr is written last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        w_arb_valid = 1'b0;
        w_arb_port  = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(r_rr_ptr) + i) % NUM_PORTS;
            if (!w_empty[idx]) begin
                w_arb_valid = 1'b1;
                w_arb_port  = PW'(idx);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = w_arb_port;
        w_issue     = w_arb_valid && !w_tag_full;
        case (r_state)
            ST_IDLE: begin
                if (w_issue && !mem_req_ready) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_grant = r_grant;
                w_issue = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_issue && mem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= PW'(NUM_PORTS - 1);
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_grant <= w_arb_port;
            end
            if (w_accept) begin
                r_rr_ptr <= w_grant;
            end
        end
    end

    assign mem_req_valid = w_issue;
    assign mem_req_op    = w_head[w_grant].op;
    assign mem_req_size  = w_head[w_grant].size;
    assign mem_req_sign  = w_head[w_grant].sign;
    assign mem_req_addr  = w_head[w_grant].addr;
    assign mem_req_wdata = w_head[w_grant].wdata;

    assign w_tag_full  = (r_tag_count == (TW+1)'(MAX_OUTSTANDING));
    assign w_resp_fire = mem_resp_valid && (r_tag_count != '0);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_tag_wr] <= w_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_wr    <= '0;
            r_tag_rd    <= '0;
            r_tag_count <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag_wr <= r_tag_wr + TW'(1);
            end
            if (w_resp_fire) begin
                r_tag_rd <= r_tag_rd + TW'(1);
            end
            case ({w_accept, w_resp_fire})
                2'b10:   r_tag_count <= r_tag_count + (TW+1)'(1);
                2'b01:   r_tag_count <= r_tag_count - (TW+1)'(1);
                default: r_tag_count <= r_tag_count;
            endcase
            if (mem_resp_valid && !w_resp_fire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign resp_valid  = w_resp_fire ? (NUM_PORTS'(1) << r_tag_mem[r_tag_rd]) : '0;
    assign resp_rdata  = w_resp_fire ? mem_resp_rdata : '0;
    assign outstanding = r_tag_count;
    assign err_orphan  = r_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter. A queue-based reference model predicts every output
// in every cycle, covering each phase of traffic, backpressure, responses and reset.
module tb_mem_req_arbiter;

    localparam int NP = 4;
    localparam int FD = 4;
    localparam int MO = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int OW = $clog2(MO) + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NP-1:0]          req_valid;
    logic [NP-1:0]          req_ready;
    logic [NP-1:0][1:0]     req_op;
    logic [NP-1:0][1:0]     req_size;
    logic [NP-1:0]          req_sign;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][DW-1:0]  req_wdata;
    logic [NP-1:0]          resp_valid;
    logic [DW-1:0]          resp_rdata;
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [1:0]             mem_req_op;
    logic [1:0]             mem_req_size;
    logic                   mem_req_sign;
    logic [AW-1:0]          mem_req_addr;
    logic [DW-1:0]          mem_req_wdata;
    logic                   mem_resp_valid;
    logic [DW-1:0]          mem_resp_rdata;
    logic [OW-1:0]          outstanding;
    logic                   err_orphan;

    mem_req_arbiter #(
        .NUM_PORTS(NP), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_op(mem_req_op), .mem_req_size(mem_req_size), .mem_req_sign(mem_req_sign),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    op;
        logic [1:0]    size;
        logic          sign;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        int       cycles;
        bit       do_rst;
        bit [3:0] mask;
        int       p_req;
        int       p_ready;
        int       p_resp;
    } phase_t;

    // Reference model: request queues, issue-order tag queue, last-granted port, held grant
    req_t q [NP][$];
    int   tagq[$];
    int   rr;
    int   lock_port;
    bit   err;

    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) q[p].delete();
        tagq.delete();
        rr        = NP - 1;
        lock_port = -1;
        err       = 1'b0;
    endfunction

    // Port that should drive mem_req this cycle, or -1 when nothing may issue.
    function automatic int exp_grant();
        if (lock_port >= 0) return lock_port;
        if (tagq.size() >= MO) return -1;
        for (int i = 1; i <= NP; i++) begin
            int p;
            p = (rr + i) % NP;
            if (q[p].size() > 0) return p;
        end
        return -1;
    endfunction

    task automatic run_cycle(input phase_t ph);
        int            g;
        logic [NP-1:0] exp_ready;
        logic [NP-1:0] exp_resp;
        bit            fire;
        @(negedge clk);
        rst = ph.do_rst;
        for (int p = 0; p < NP; p++) begin
            req_valid[p] = ph.mask[p] && ($urandom_range(99) < ph.p_req);
            req_op[p]    = 2'($urandom_range(1, 3));
            req_size[p]  = 2'($urandom_range(0, 2));
            req_sign[p]  = 1'($urandom);
            req_addr[p]  = $urandom;
            req_wdata[p] = $urandom;
        end
        mem_req_ready  = ($urandom_range(99) < ph.p_ready);
        mem_resp_valid = ($urandom_range(99) < ph.p_resp);
        mem_resp_rdata = $urandom;
        #1;
        if (rst) model_reset();

        g = exp_grant();
        for (int p = 0; p < NP; p++) exp_ready[p] = (q[p].size() < FD);
        fire     = mem_resp_valid && (tagq.size() > 0);
        exp_resp = fire ? (NP'(1) << tagq[0]) : '0;

        check("mem_req_valid", mem_req_valid, g >= 0);
        if (g >= 0)
            check("payload", {mem_req_op, mem_req_size, mem_req_sign, mem_req_addr, mem_req_wdata}, q[g][0]);
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, exp_resp);
        check("resp_rdata", resp_rdata, fire ? mem_resp_rdata : '0);
        check("outstanding", outstanding, tagq.size());
        check("err_orphan", err_orphan, err);

        if (!rst) begin
            if (mem_resp_valid && !fire) err = 1'b1;
            if (fire) void'(tagq.pop_front());
            if (g >= 0 && mem_req_ready) begin
                void'(q[g].pop_front());
                tagq.push_back(g);
                rr        = g;
                lock_port = -1;
            end else if (g >= 0) begin
                lock_port = g;
            end
            for (int p = 0; p < NP; p++) begin
                if (req_valid[p] && exp_ready[p])
                    q[p].push_back('{op: req_op[p], size: req_size[p], sign: req_sign[p],
                                     addr: req_addr[p], wdata: req_wdata[p]});
            end
        end
    endtask

    phase_t phases [12];

    initial begin
        rst            = 1'b1;
        req_valid      = '0;
        req_op         = '0;
        req_size       = '0;
        req_sign       = '0;
        req_addr       = '0;
        req_wdata      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        model_reset();

        //            cycles rst mask     req ready resp
        phases[0]  = '{3,   1, 4'b0000,   0,   0,   0};   // reset values
        phases[1]  = '{40,  0, 4'b0100,  30, 100,  50};   // single port 2
        phases[2]  = '{30,  0, 4'b1111, 100, 100,   0};   // fairness, then tag FIFO full
        phases[3]  = '{60,  0, 4'b1111, 100, 100,  30};   // full tag FIFO with responses trickling in
        phases[4]  = '{30,  0, 4'b0001, 100,   0,   0};   // port 0 fills its FIFO under backpressure
        phases[5]  = '{300, 0, 4'b1111,  50,  30,  50};   // backpressure with grant lock
        phases[6]  = '{30,  0, 4'b0000,   0,  50, 100};   // drain, then orphan responses
        phases[7]  = '{3,   1, 4'b1111,  80,  50,  50};   // reset while traffic is in flight
        phases[8]  = '{400, 0, 4'b1111,  60,  60,  40};   // mixed random traffic
        phases[9]  = '{2,   1, 4'b1111, 100, 100,  50};   // reset with requests outstanding
        phases[10] = '{10,  0, 4'b0000,   0,   0, 100};   // late responses after reset
        phases[11] = '{300, 0, 4'b1111,  70,  80,  60};

        foreach (phases[i]) begin
            for (int c = 0; c < phases[i].cycles; c++) run_cycle(phases[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
